// File: rtl/riscv_apu_arbiter.sv
// Shares one APU port between NB_CORES dispatchers; an in-order tag FIFO routes results back.
// Build option: define RISCV_APU_ARB_RR_EN for round-robin selection (default is fixed priority).

module riscv_apu_arbiter_lane #(
  parameter int CW = 2,
  parameter int ID = 0
) (
  input  logic [CW-1:0] sel,
  input  logic [CW-1:0] head,
  input  logic          push,
  input  logic          pop,
  output logic          gnt,
  output logic          valid
);
  assign gnt   = push & (sel == CW'(ID));
  assign valid = pop & (head == CW'(ID));
endmodule

module riscv_apu_arbiter #(
  parameter int NB_CORES = 4,
  parameter int WOP      = 64,
  parameter int WRES     = 32,
  parameter int DEPTH    = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NB_CORES-1:0]           core_req_i,
  input  logic [NB_CORES-1:0][WOP-1:0]  core_op_i,
  output logic [NB_CORES-1:0]           core_gnt_o,
  output logic [NB_CORES-1:0]           core_valid_o,
  output logic [WRES-1:0]               core_result_o,
  output logic                          apu_req_o,
  output logic [WOP-1:0]                apu_op_o,
  input  logic                          apu_gnt_i,
  input  logic                          apu_valid_i,
  input  logic [WRES-1:0]               apu_result_i,
  output logic                          apu_ready_o,
  output logic                          busy_o,
  output logic                          err_o
);
  localparam int CW   = $clog2(NB_CORES);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][CW-1:0] tag_q;
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [CNTW-1:0]          cnt;
  logic                     err_q;
  logic [CW-1:0]            sel, head;
  logic                     any_req, empty, full, pop, push, block;

  assign any_req = |core_req_i;
  assign empty   = (cnt == '0);
  assign full    = (cnt == CNTW'(DEPTH));
  assign pop     = apu_valid_i & ~empty;
  assign block   = full & ~pop;
  assign push    = apu_req_o & apu_gnt_i;
  assign head    = tag_q[rd_ptr];

  assign apu_req_o     = any_req & ~block;
  assign apu_op_o      = any_req ? core_op_i[sel] : '0;
  assign apu_ready_o   = 1'b1;
  assign core_result_o = apu_result_i;
  assign busy_o        = ~empty;
  assign err_o         = err_q;

`ifdef RISCV_APU_ARB_RR_EN
  logic [CW-1:0] rr_ptr;

  always_comb begin
    int  idx;
    logic found;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NB_CORES; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NB_CORES) idx = idx - NB_CORES;
      if (!found && core_req_i[idx]) begin
        sel   = CW'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rr_ptr <= '0;
    else if (push) rr_ptr <= (sel == CW'(NB_CORES - 1)) ? '0 : sel + CW'(1);
  end
`else
  always_comb begin
    sel = '0;
    for (int i = NB_CORES - 1; i >= 0; i--)
      if (core_req_i[i]) sel = CW'(i);
  end
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Results come back in issue order, so the FIFO head always names the owner.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) begin
        tag_q[wr_ptr] <= sel;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNTW'(1);
        2'b01:   cnt <= cnt - CNTW'(1);
        default: cnt <= cnt;
      endcase
      if (apu_valid_i && empty) err_q <= 1'b1;
    end
  end

  for (genvar g = 0; g < NB_CORES; g++) begin : g_lane
    riscv_apu_arbiter_lane #(.CW(CW), .ID(g)) u_lane (
      .sel   (sel),
      .head  (head),
      .push  (push),
      .pop   (pop),
      .gnt   (core_gnt_o[g]),
      .valid (core_valid_o[g])
    );
  end
endmodule

// File: tb/tb_riscv_apu_arbiter.sv
// Directed bench for riscv_apu_arbiter with a tag scoreboard for result routing.
module tb_riscv_apu_arbiter;
  localparam int NB = 4, WOP = 64, WRES = 32, DEPTH = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NB-1:0]           core_req;
  logic [NB-1:0][WOP-1:0]  core_op;
  logic [NB-1:0]           core_gnt, core_valid;
  logic [WRES-1:0]         core_result;
  logic                    apu_req, apu_gnt, apu_valid, apu_ready, busy, err;
  logic [WOP-1:0]          apu_op;
  logic [WRES-1:0]         apu_result;

  int checks = 0, errors = 0, nres = 0, rr = 0;
  logic merr = 1'b0;
  int sb[$];

  always #5 clk = ~clk;

  riscv_apu_arbiter #(.NB_CORES(NB), .WOP(WOP), .WRES(WRES), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .core_req_i(core_req), .core_op_i(core_op),
    .core_gnt_o(core_gnt), .core_valid_o(core_valid), .core_result_o(core_result),
    .apu_req_o(apu_req), .apu_op_o(apu_op), .apu_gnt_i(apu_gnt),
    .apu_valid_i(apu_valid), .apu_result_i(apu_result), .apu_ready_o(apu_ready),
    .busy_o(busy), .err_o(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int msel(input logic [NB-1:0] req);
`ifdef RISCV_APU_ARB_RR_EN
    for (int k = 0; k < NB; k++) if (req[(rr + k) % NB]) return (rr + k) % NB;
`else
    for (int k = 0; k < NB; k++) if (req[k]) return k;
`endif
    return 0;
  endfunction

  // One clock cycle: drive, check at negedge against the model, update the model.
  task automatic cyc(input logic [NB-1:0] req, input logic gnt, input logic vld,
                     input int exp_g, input string tag);
    int s; logic p, blk, ereq, psh; logic [WRES-1:0] res;
    res = 32'h5000_0000 + nres; nres++;
    core_req = req; apu_gnt = gnt; apu_valid = vld; apu_result = res;
    s    = msel(req);
    p    = vld && (sb.size() > 0);
    blk  = (sb.size() == DEPTH) && !p;
    ereq = (|req) && !blk;
    psh  = ereq && gnt;
    @(negedge clk);
    chk({tag, ".apu_req"}, 64'(apu_req), 64'(ereq));
    chk({tag, ".gnt"}, 64'(core_gnt), psh ? 64'(1) << s : 64'(0));
    if (exp_g >= 0) chk({tag, ".gnt_dir"}, 64'(core_gnt), 64'(exp_g));
    chk({tag, ".op"}, apu_op, (|req) ? core_op[s] : 64'(0));
    chk({tag, ".valid"}, 64'(core_valid), p ? 64'(1) << sb[0] : 64'(0));
    if (p) chk({tag, ".result"}, 64'(core_result), 64'(res));
    chk({tag, ".busy"}, 64'(busy), 64'(sb.size() != 0));
    chk({tag, ".err"}, 64'(err), 64'(merr));
    if (vld && sb.size() == 0) merr = 1'b1;
    if (p) void'(sb.pop_front());
    if (psh) begin
      sb.push_back(s);
      rr = (s + 1) % NB;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input string tag);
    core_req = '0; apu_gnt = 1'b0; apu_valid = 1'b0; apu_result = '0;
    rst_n = 1'b0;
    #2;
    chk({tag, ".gnt"}, 64'(core_gnt), 64'(0));
    chk({tag, ".valid"}, 64'(core_valid), 64'(0));
    chk({tag, ".result"}, 64'(core_result), 64'(0));
    chk({tag, ".apu_req"}, 64'(apu_req), 64'(0));
    chk({tag, ".apu_op"}, apu_op, 64'(0));
    chk({tag, ".busy"}, 64'(busy), 64'(0));
    chk({tag, ".err"}, 64'(err), 64'(0));
    chk({tag, ".ready"}, 64'(apu_ready), 64'(1));
    sb.delete(); merr = 1'b0; rr = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  int g_seq[5];

  initial begin
    rst_n = 1'b0;
    core_req = '0; apu_gnt = 1'b0; apu_valid = 1'b0; apu_result = '0;
    for (int i = 0; i < NB; i++) core_op[i] = {32'hA5A5_A5A5, 32'(i + 1) * 32'h0101_0101};
`ifdef RISCV_APU_ARB_RR_EN
    g_seq = '{1, 2, 4, 8, 1};
`else
    g_seq = '{1, 1, 1, 1, 1};
`endif
    #1;
    do_reset("rst0");

    // single core, 3-cycle APU latency
    cyc(4'b0100, 1'b1, 1'b0, 4, "single.c0");
    cyc(4'b0000, 1'b0, 1'b0, -1, "single.c1");
    cyc(4'b0000, 1'b0, 1'b0, -1, "single.c2");
    cyc(4'b0000, 1'b0, 1'b1, -1, "single.c3");
    cyc(4'b0000, 1'b0, 1'b0, -1, "single.c4");

    // contention with 1-cycle return
    do_reset("rst1");
    cyc(4'b1111, 1'b1, 1'b0, g_seq[0], "cont.g0");
    for (int k = 1; k < 5; k++) cyc(4'b1111, 1'b1, 1'b1, g_seq[k], $sformatf("cont.g%0d", k));
    cyc(4'b0000, 1'b0, 1'b1, -1, "cont.drain");

    // full FIFO, then push+pop together at full
    do_reset("rst2");
    cyc(4'b0011, 1'b1, 1'b0, -1, "full.g0");
    cyc(4'b0011, 1'b1, 1'b0, -1, "full.g1");
    cyc(4'b0011, 1'b1, 1'b0, 0, "full.blk0");
    cyc(4'b0011, 1'b1, 1'b0, 0, "full.blk1");
    cyc(4'b0011, 1'b1, 1'b1, -1, "full.pushpop");
    cyc(4'b0011, 1'b1, 1'b0, 0, "full.blk2");
    cyc(4'b0000, 1'b0, 1'b1, -1, "full.d0");
    cyc(4'b0000, 1'b0, 1'b1, -1, "full.d1");
    cyc(4'b0000, 1'b0, 1'b0, -1, "full.idle");

    // backpressure from the APU
    do_reset("rst3");
    for (int k = 0; k < 3; k++) cyc(4'b0010, 1'b0, 1'b0, 0, $sformatf("bp.c%0d", k));

    // spurious result sets a sticky error
    cyc(4'b0000, 1'b0, 1'b1, -1, "spur.c0");
    cyc(4'b0000, 1'b0, 1'b0, -1, "spur.c1");
    cyc(4'b0010, 1'b1, 1'b0, 2, "spur.c2");
    cyc(4'b0000, 1'b0, 1'b1, -1, "spur.c3");
    do_reset("rst4");

    // reset with two operations outstanding
    cyc(4'b1000, 1'b1, 1'b0, 8, "mid.g0");
    cyc(4'b1000, 1'b1, 1'b0, 8, "mid.g1");
    do_reset("rst5");
    cyc(4'b1111, 1'b1, 1'b0, 1, "mid.post");
    cyc(4'b0000, 1'b0, 1'b1, -1, "mid.ret");
    cyc(4'b0000, 1'b0, 1'b0, -1, "mid.idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
